// File: rtl/pckg.sv
// Shared types, default geometry and a width helper for the KxK convolution engine.
package pckg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MAC  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IMG_W      = 4;
   localparam int DEF_IMG_H      = 4;
   localparam int DEF_K          = 2;
   localparam int DEF_STRIDE     = 1;

   // Bits needed to index n items; never narrower than one bit.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate for one output window, then ReLU and saturation into the output register.
module conv_mac import pckg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic                         first_i,
   input  logic                         last_i,
   input  logic                         relu_i,
   input  logic signed [DATA_WIDTH-1:0] pix_i,
   input  logic signed [DATA_WIDTH-1:0] coef_i,
   output logic signed [DATA_WIDTH-1:0] pixel_o
);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   function automatic logic signed [ACC_WIDTH-1:0] relu(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic                        en
   );
      return (en && a[ACC_WIDTH-1]) ? '0 : a;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat(
      input logic signed [ACC_WIDTH-1:0] a
   );
      if (a > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
      if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
      return a[DATA_WIDTH-1:0];
   endfunction

   logic signed [2*DATA_WIDTH-1:0] w_prod_p0;
   logic signed [ACC_WIDTH-1:0]    w_sum_p0;
   logic signed [ACC_WIDTH-1:0]    r_acc_p1;
   logic signed [DATA_WIDTH-1:0]   r_pixel_p1;

   // Stage p0: product and running sum; tap 0 restarts the sum
   assign w_prod_p0 = pix_i * coef_i;
   assign w_sum_p0  = first_i ? ACC_WIDTH'(w_prod_p0)
                              : r_acc_p1 + ACC_WIDTH'(w_prod_p0);

   // Stage p1: accumulator and finished output pixel
   always_ff @(posedge clk_i) begin
      if (en_i) r_acc_p1 <= w_sum_p0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             r_pixel_p1 <= '0;
      else if (en_i && last_i) r_pixel_p1 <= sat(relu(w_sum_p0, relu_i));
   end

   assign pixel_o = r_pixel_p1;

endmodule

// File: rtl/conv_kxk_engine.sv
// Frame-buffered KxK strided convolution: load a whole frame, then emit one window per K*K+1 cycles.
module conv_kxk_engine import pckg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int K          = DEF_K,
   parameter int STRIDE     = DEF_STRIDE
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              valid_i,
   output logic                              ready_o,
   input  logic signed [DATA_WIDTH-1:0]      pixel_i,
   input  logic [K*K-1:0][DATA_WIDTH-1:0]    filter_i,
   input  logic                              relu_en_i,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic signed [DATA_WIDTH-1:0]      pixel_o,
   output logic                              frame_done_o
);

   localparam int NPIX      = IMG_W * IMG_H;
   localparam int NTAP      = K * K;
   localparam int OUT_W     = (IMG_W - K) / STRIDE + 1;
   localparam int OUT_H     = (IMG_H - K) / STRIDE + 1;
   localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(NTAP);
   localparam int PIX_AW    = cw(NPIX);
   localparam int TAP_W     = cw(NTAP);
   localparam int KW        = cw(K);
   localparam int OCW       = cw(OUT_W);
   localparam int ORW       = cw(OUT_H);

   state_t                          r_state, w_state_nxt;
   logic [PIX_AW-1:0]               r_pix_cnt;
   logic [TAP_W-1:0]                r_tap;
   logic [KW-1:0]                   r_kr, r_kc;
   logic [OCW-1:0]                  r_ocol;
   logic [ORW-1:0]                  r_orow;
   logic                            r_relu;
   logic                            r_frame_done;
   logic signed [DATA_WIDTH-1:0]    r_fbuf [NPIX];
   logic [K*K-1:0][DATA_WIDTH-1:0]  r_filter;

   logic                            w_accept, w_last_pix, w_last_tap;
   logic                            w_hs, w_last_win;
   logic [PIX_AW-1:0]               w_addr;

   assign w_accept   = valid_i && ready_o;
   assign w_last_pix = (r_pix_cnt == PIX_AW'(NPIX - 1));
   assign w_last_tap = (r_tap == TAP_W'(NTAP - 1));
   assign w_hs       = valid_o && ready_i;
   assign w_last_win = (r_ocol == OCW'(OUT_W - 1)) && (r_orow == ORW'(OUT_H - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      case (r_state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) w_state_nxt = LOAD;
         end
         LOAD: begin
            ready_o = 1'b1;
            if (valid_i && w_last_pix) w_state_nxt = MAC;
         end
         MAC: begin
            if (w_last_tap) w_state_nxt = OUT;
         end
         OUT: begin
            valid_o = 1'b1;
            if (ready_i) w_state_nxt = w_last_win ? IDLE : MAC;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Tap and window counters always wrap to zero, so each frame starts from the origin
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pix_cnt    <= '0;
         r_tap        <= '0;
         r_kr         <= '0;
         r_kc         <= '0;
         r_ocol       <= '0;
         r_orow       <= '0;
         r_relu       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_hs && w_last_win;
         if (w_accept) r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
         if (w_accept && (r_state == IDLE)) r_relu <= relu_en_i;
         if (r_state == MAC) begin
            if (w_last_tap) begin
               r_tap <= '0;
               r_kr  <= '0;
               r_kc  <= '0;
            end else begin
               r_tap <= r_tap + 1'b1;
               if (r_kc == KW'(K - 1)) begin
                  r_kc <= '0;
                  r_kr <= r_kr + 1'b1;
               end else begin
                  r_kc <= r_kc + 1'b1;
               end
            end
         end
         if (w_hs) begin
            if (r_ocol == OCW'(OUT_W - 1)) begin
               r_ocol <= '0;
               r_orow <= w_last_win ? '0 : r_orow + 1'b1;
            end else begin
               r_ocol <= r_ocol + 1'b1;
            end
         end
      end
   end

   // Frame buffer and coefficients are plain data: no reset, a partial frame is simply overwritten
   always_ff @(posedge clk_i) begin
      if (w_accept) r_fbuf[r_pix_cnt] <= pixel_i;
      if (w_accept && (r_state == IDLE)) r_filter <= filter_i;
   end

   assign w_addr = PIX_AW'((32'(r_orow) * STRIDE + 32'(r_kr)) * IMG_W
                           + 32'(r_ocol) * STRIDE + 32'(r_kc));

   conv_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (r_state == MAC),
      .first_i (r_tap == '0),
      .last_i  (w_last_tap),
      .relu_i  (r_relu),
      .pix_i   (r_fbuf[w_addr]),
      .coef_i  (r_filter[r_tap]),
      .pixel_o (pixel_o)
   );

   assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_conv_kxk_engine.sv
// Directed bench: three engine geometries on a 4x4 image with hand-computed expected outputs.
module tb_conv_kxk_engine;

   typedef logic signed [7:0] sq_t [$];

   logic clk = 1'b0;
   logic rst_n;
   logic va, vb, rdy0, relu0;
   logic signed [7:0] pix;
   logic [3:0][7:0] filt0, filt1;
   logic [8:0][7:0] filt2;

   logic ready0, vo0, fd0, ready1, vo1, fd1, ready2, vo2, fd2;
   logic signed [7:0] px0, px1, px2;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int exp_v [9];
   sq_t q0, q1, q2;

   always #5 clk = ~clk;

   conv_kxk_engine #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .K(2), .STRIDE(1)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .ready_o(ready0), .pixel_i(pix),
      .filter_i(filt0), .relu_en_i(relu0), .valid_o(vo0), .ready_i(rdy0),
      .pixel_o(px0), .frame_done_o(fd0));

   conv_kxk_engine #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vb), .ready_o(ready1), .pixel_i(pix),
      .filter_i(filt1), .relu_en_i(1'b0), .valid_o(vo1), .ready_i(1'b1),
      .pixel_o(px1), .frame_done_o(fd1));

   conv_kxk_engine #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vb), .ready_o(ready2), .pixel_i(pix),
      .filter_i(filt2), .relu_en_i(1'b0), .valid_o(vo2), .ready_i(1'b1),
      .pixel_o(px2), .frame_done_o(fd2));

   always @(posedge clk) begin
      if (vo0 && rdy0) q0.push_back(px0);
      if (vo1) q1.push_back(px1);
      if (vo2) q2.push_back(px2);
      if (fd0) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag, input sq_t q, input int base, input int n);
      chk({tag, "_count"}, q.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < q.size()) begin
            chk($sformatf("%s_%0d", tag, i), 32'(q[base + i]), exp_v[i]);
         end else begin
            checks++;
            errors++;
            $error("FAIL %s_%0d: observed none, expected %0d", tag, i, exp_v[i]);
         end
      end
   endtask

   task automatic set_seq(input int sign);
      int s [9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
      for (int i = 0; i < 9; i++) exp_v[i] = s[i] * sign;
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < 9; i++) exp_v[i] = v;
   endtask

   // Called on a falling edge; returns on the falling edge after the last pixel is taken.
   task automatic send(input int mode, input bit to_b);
      int n = 0;
      while (!ready0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(ready0), 1);
      for (int i = 0; i < 16; i++) begin
         pix = (mode == 0) ? 8'(i + 1) : 8'sd127;
         va  = 1'b1;
         vb  = to_b;
         @(negedge clk);
      end
      va = 1'b0;
      vb = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!fd0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, 32'(fd0), 1);
   endtask

   initial begin
      int b0, b1, b2, fdb, n;
      logic signed [7:0] held;

      rst_n = 1'b0;
      va = 1'b0; vb = 1'b0; rdy0 = 1'b1; relu0 = 1'b0; pix = '0;
      filt0 = {4{8'sd1}};
      filt1 = {4{8'sd1}};
      filt2 = {9{8'sd1}};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(ready0), 1);
      chk("rst_valid", 32'(vo0), 0);
      chk("rst_pixel", 32'(px0), 0);
      chk("rst_done", 32'(fd0), 0);

      // Ramp 1..16, all-ones filters on all three geometries
      b0 = q0.size(); b1 = q1.size(); b2 = q2.size(); fdb = fd_cnt;
      send(0, 1'b1);
      wait_done("ramp");
      chk("done_ready", 32'(ready0), 1);
      @(negedge clk);
      chk("done_pulse_end", 32'(fd0), 0);
      chk("done_pulses", fd_cnt - fdb, 1);
      set_seq(1);
      chk_q("k2s1", q0, b0, 9);
      exp_v[0] = 14; exp_v[1] = 22; exp_v[2] = 46; exp_v[3] = 54;
      chk_q("k2s2", q1, b1, 4);
      exp_v[0] = 54; exp_v[1] = 63; exp_v[2] = 90; exp_v[3] = 99;
      chk_q("k3s1", q2, b2, 4);

      // Saturation both ways
      filt0 = {4{8'sd127}};
      b0 = q0.size();
      send(1, 1'b0);
      wait_done("satp");
      set_all(127);
      chk_q("sat_pos", q0, b0, 9);
      filt0 = {4{8'h80}};
      b0 = q0.size();
      send(1, 1'b0);
      wait_done("satn");
      set_all(-128);
      chk_q("sat_neg", q0, b0, 9);

      // Negative filter without and with ReLU; mid-frame input changes must not matter
      filt0 = {4{8'hFF}};
      relu0 = 1'b0;
      b0 = q0.size();
      send(0, 1'b0);
      wait_done("neg");
      set_seq(-1);
      chk_q("neg", q0, b0, 9);
      relu0 = 1'b1;
      b0 = q0.size();
      send(0, 1'b0);
      filt0 = {4{8'sd1}};
      relu0 = 1'b0;
      wait_done("relu");
      set_all(0);
      chk_q("relu", q0, b0, 9);

      // Back-pressure: first output held for 5 cycles, then K*K+1 spacing
      filt0 = {4{8'sd1}};
      rdy0 = 1'b0;
      b0 = q0.size();
      send(0, 1'b0);
      n = 0;
      while (!vo0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", 32'(vo0), 1);
      held = px0;
      chk("bp_first", 32'(held), 14);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(vo0), 1);
         chk("bp_hold_pixel", 32'(px0), 32'(held));
      end
      rdy0 = 1'b1;
      @(negedge clk);
      chk("bp_drop", 32'(vo0), 0);
      repeat (3) @(negedge clk);
      chk("bp_gap", 32'(vo0), 0);
      @(negedge clk);
      chk("bp_next_valid", 32'(vo0), 1);
      chk("bp_next_pixel", 32'(px0), 18);
      wait_done("bp");
      set_seq(1);
      chk_q("bp", q0, b0, 9);

      // Reset in the middle of a frame, then a clean frame
      b0 = q0.size();
      send(0, 1'b0);
      n = 0;
      while ((q0.size() - b0) < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_outs", q0.size() - b0, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(vo0), 0);
      chk("mid_rst_pixel", 32'(px0), 0);
      chk("mid_rst_done", 32'(fd0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(ready0), 1);
      b0 = q0.size();
      fdb = fd_cnt;
      send(0, 1'b0);
      wait_done("after_rst");
      @(negedge clk);
      chk("after_rst_pulses", fd_cnt - fdb, 1);
      chk_q("after_rst", q0, b0, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_kxk_engine.md
CONV_KXK_ENGINE -- requirements
Module: conv_kxk_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning pixel/coefficient width, signed two's complement.
REQ-002 SHALL have parameter IMG_W, default 4, meaning input image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 4, meaning input image height in pixels.
REQ-004 SHALL have parameter K, default 2, meaning square filter side, 2 <= K <= min(IMG_W, IMG_H).
REQ-005 SHALL have parameter STRIDE, default 1, meaning window step in both axes, >= 1.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have ports valid_i input 1 and ready_o output 1, forming the input pixel handshake.
REQ-009 SHALL have port pixel_i  input  DATA_WIDTH  raster-order input pixel.
REQ-010 SHALL have port filter_i  input  array of K*K x DATA_WIDTH  coefficients, row-major.
REQ-011 SHALL have port relu_en_i  input  1  clamp negative results to 0 when 1.
REQ-012 SHALL have ports valid_o output 1 and ready_i input 1, forming the output handshake.
REQ-013 SHALL have port pixel_o  output  DATA_WIDTH  convolved pixel, raster order.
REQ-014 SHALL have port frame_done_o  output  1  one-cycle pulse after the last output is accepted.

Function
REQ-015 SHALL use states IDLE, LOAD, MAC, OUT; IDLE->LOAD on first accepted pixel; LOAD->MAC after IMG_W*IMG_H-th accepted pixel; MAC->OUT after K*K-th tap; OUT->MAC on handshake if windows remain, else OUT->IDLE.
REQ-016 SHALL assert ready_o only in IDLE and LOAD; a pixel is accepted when valid_i && ready_o; valid_i ignored otherwise.
REQ-017 SHALL sample filter_i and relu_en_i in the cycle the first pixel of a frame is accepted and hold them for the whole frame.
REQ-018 SHALL store accepted pixels in a frame buffer at raster index row*IMG_W+col.
REQ-019 SHALL produce OUT_W = (IMG_W-K)/STRIDE+1 by OUT_H = (IMG_H-K)/STRIDE+1 outputs, windows anchored at (r*STRIDE, c*STRIDE), column index fastest.
REQ-020 SHALL compute each output in MAC with one multiply-accumulate per cycle, exactly K*K cycles; tap 0 loads the accumulator rather than adding.
REQ-021 SHALL use accumulator width 2*DATA_WIDTH + clog2(K*K), signed, with no intermediate overflow.
REQ-022 SHALL apply ReLU (if enabled), then saturate to signed DATA_WIDTH range, registering the result into pixel_o on MAC->OUT.
REQ-023 SHALL assert valid_o throughout OUT, holding pixel_o stable until ready_i is high; transfer completes on valid_o && ready_i.
REQ-024 SHALL deassert valid_o the cycle after a transfer; the next output appears K*K+1 cycles after the prior handshake.
REQ-025 SHALL pulse frame_done_o the cycle after the final handshake, coincident with return to IDLE.
REQ-026 SHALL accept a new frame's first pixel in the first IDLE cycle after frame_done_o.

Reset
REQ-027 SHALL, on rst_ni low at any time including mid-LOAD/MAC/OUT, go to IDLE immediately with valid_o=0, pixel_o=0, frame_done_o=0, ready_o=1 after release, and all counters cleared.
REQ-028 SHALL NOT require frame buffer contents to be reset; a partial frame is discarded.

Structure
REQ-029 SHALL take state_t (IDLE, LOAD, MAC, OUT) and default DATA_WIDTH/IMG_W/IMG_H/K/STRIDE from the shared package pckg.
REQ-030 SHALL place the multiply-accumulate, ReLU and saturation datapath in one sub-module conv_mac; the sequencing FSM and counters remain in conv_kxk_engine.
REQ-031 SHALL compute all derived sizes (OUT_W, OUT_H, ACC_WIDTH, counter widths) as localparams.

Verification
REQ-032 SHALL cover 4x4, K=2, STRIDE=1, pixels 1..16, filter all 1 -> outputs 14,18,22,30,34,38,46,50,54, then one frame_done_o pulse.
REQ-033 SHALL cover 4x4, K=2, STRIDE=2, same data -> outputs 14,22,46,54; K=3, STRIDE=1 -> 54,63,90,99.
REQ-034 SHALL cover DATA_WIDTH=8, all pixels 127, filter all 127 -> every output 127 (positive saturation); filter all -128 -> -128.
REQ-035 SHALL cover filter all -1, pixels 1..16, K=2: relu_en_i=0 -> first output -14; relu_en_i=1 -> all outputs 0.
REQ-036 SHALL cover ready_i held low 5 cycles in OUT -> valid_o stays 1, pixel_o unchanged, no output lost or duplicated.
REQ-037 SHALL cover rst_ni pulsed low mid-MAC of frame 1 -> valid_o=0 at once, then a fresh frame gives the REQ-032 outputs exactly.
